// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, mux selects,
// ALU operations and branch conditions.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BUBBLE = 7'b0000000;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_ZERO = 2'b01;
    localparam logic [1:0] SRCA_PC   = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_op_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Everything the Execute stage needs from Decode.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_ctrl;
        logic [2:0] br_funct3;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7-driven ALU operation decode; flags funct3 values with no
// operation at the configured ALUControl width.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  op5,
    output logic [ALU_CTRL_W-1:0] alu_op,
    output logic                  funct_illegal
);

    alu_op_t    op;
    logic       is_shift;
    logic [3:0] op_bits;

    always_comb begin
        op            = ALU_ADD;
        is_shift      = 1'b0;
        funct_illegal = 1'b0;
        case (funct3)
            3'b000: op = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
            3'b001: begin op = ALU_SLL; is_shift = 1'b1; end
            3'b010: op = ALU_SLT;
            3'b100: op = ALU_XOR;
            3'b101: begin op = funct7b5 ? ALU_SRA : ALU_SRL; is_shift = 1'b1; end
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: funct_illegal = 1'b1;
        endcase
        // Shift encodings do not fit in a 3-bit ALUControl.
        if (ALU_CTRL_W == 3 && is_shift) begin
            funct_illegal = 1'b1;
        end
    end

    assign op_bits = op;
    assign alu_op  = op_bits[ALU_CTRL_W-1:0];

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes in D and carries controls through the
// E, M and W registers; illegal instructions pulse IllegalW in Writeback.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W     = 4,
    parameter bit EN_JALR        = 1'b1,
    parameter bit EN_AUIPC       = 1'b1,
    parameter bit EN_FULL_BRANCH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            OpD,
    input  logic [2:0]            Funct3D,
    input  logic                  Funct7b5D,
    input  logic                  FlushE,
    input  logic                  ZeroE,
    input  logic                  LtE,
    input  logic                  LtuE,
    output logic [2:0]            ImmSrcD,
    output logic [1:0]            ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  PCSrcE,
    output logic                  JalrE,
    output logic [1:0]            ResultSrcE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic                  IllegalW,
    output logic                  IllegalSeen
);

    ctrl_t                 dec;
    ctrl_t                 ctrl_e;
    logic [2:0]            imm_src_d;
    logic                  illegal_d;
    logic                  branch_ok;
    logic [ALU_CTRL_W-1:0] funct_op;
    logic                  funct_illegal;
    logic                  taken_e;

    logic                  reg_write_m;
    logic                  mem_write_m;
    logic [1:0]            result_src_m;
    logic                  illegal_m;
    logic                  reg_write_w;
    logic [1:0]            result_src_w;
    logic                  illegal_w;
    logic                  illegal_seen;

    alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decoder (
        .funct3       (Funct3D),
        .funct7b5     (Funct7b5D),
        .op5          (OpD[5]),
        .alu_op       (funct_op),
        .funct_illegal(funct_illegal)
    );

    // beq/bne are always present; the ordered compares only when enabled.
    always_comb begin
        case (Funct3D)
            BR_EQ, BR_NE:                  branch_ok = 1'b1;
            BR_LT, BR_GE, BR_LTU, BR_GEU:  branch_ok = EN_FULL_BRANCH;
            default:                       branch_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec       = '0;
        imm_src_d = IMM_I;
        illegal_d = 1'b0;
        case (OpD)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_MEM;
                dec.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                imm_src_d     = IMM_S;
                dec.alu_src_b = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
            end
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = 4'(funct_op);
                illegal_d     = funct_illegal;
            end
            OP_IALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_ctrl  = 4'(funct_op);
                illegal_d     = funct_illegal;
            end
            OP_BRANCH: begin
                dec.branch    = 1'b1;
                imm_src_d     = IMM_B;
                dec.alu_ctrl  = ALU_SUB;
                dec.br_funct3 = Funct3D;
                illegal_d     = !branch_ok;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                imm_src_d      = IMM_J;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_ctrl   = ALU_ADD;
                illegal_d      = !EN_JALR;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                imm_src_d      = IMM_U;
                dec.result_src = RES_IMM;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                imm_src_d     = IMM_U;
                dec.alu_src_a = SRCA_PC;
                dec.alu_src_b = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                illegal_d     = !EN_AUIPC;
            end
            OP_BUBBLE: ;
            default: illegal_d = 1'b1;
        endcase
        // An illegal instruction travels as a bubble that only carries its flag.
        if (illegal_d) begin
            dec       = '0;
            imm_src_d = IMM_I;
        end
        dec.illegal = illegal_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e       <= '0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            illegal_m    <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= RES_ALU;
            illegal_w    <= 1'b0;
            illegal_seen <= 1'b0;
        end else begin
            ctrl_e       <= FlushE ? '0 : dec;
            reg_write_m  <= ctrl_e.reg_write;
            mem_write_m  <= ctrl_e.mem_write;
            result_src_m <= ctrl_e.result_src;
            illegal_m    <= ctrl_e.illegal;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            illegal_w    <= illegal_m;
            // Loaded on the same edge as IllegalW so both rise together.
            illegal_seen <= illegal_seen | illegal_m;
        end
    end

    always_comb begin
        case (ctrl_e.br_funct3)
            BR_EQ:   taken_e = ZeroE;
            BR_NE:   taken_e = !ZeroE;
            BR_LT:   taken_e = LtE;
            BR_GE:   taken_e = !LtE;
            BR_LTU:  taken_e = LtuE;
            BR_GEU:  taken_e = !LtuE;
            default: taken_e = 1'b0;
        endcase
    end

    assign ImmSrcD     = imm_src_d;
    assign ALUSrcAE    = ctrl_e.alu_src_a;
    assign ALUSrcBE    = ctrl_e.alu_src_b;
    assign ALUControlE = ctrl_e.alu_ctrl[ALU_CTRL_W-1:0];
    assign PCSrcE      = ctrl_e.jump | (ctrl_e.branch & taken_e);
    assign JalrE       = ctrl_e.jalr;
    assign ResultSrcE  = ctrl_e.result_src;
    assign RegWriteM   = reg_write_m;
    assign MemWriteM   = mem_write_m;
    assign ResultSrcM  = result_src_m;
    assign RegWriteW   = reg_write_w;
    assign ResultSrcW  = result_src_w;
    assign IllegalW    = illegal_w;
    assign IllegalSeen = illegal_seen;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: a full-featured instance and a reduced one
// (3-bit ALU, no jalr/auipc, beq/bne only) share one randomized stream.
module tb_pipe_controller;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] res;
        logic [1:0] srca;
        logic       srcb;
        logic [3:0] alu;
        logic [2:0] f3;
        logic       illegal;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [2:0] imm;
        exp_t       e;
    } item_t;

    localparam int ITEM_W = $bits(item_t);

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, flush, ze, lte, ltue;

    wire [1:0][2:0] imm_d;
    wire [1:0][1:0] srca_e, res_e, res_m, res_w;
    wire [1:0]      srcb_e, pcsrc_e, jalr_e, rw_m, mw_m, rw_w, ill_w, seen;
    wire [3:0]      alu0;
    wire [2:0]      alu1;

    logic [ITEM_W-1:0] exp_q0[$];
    logic [ITEM_W-1:0] exp_q1[$];
    exp_t mdl_e[2], mdl_m[2], mdl_w[2];
    logic mdl_seen[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_controller dut0 (
        .clk(clk), .rst(rst), .OpD(op), .Funct3D(f3), .Funct7b5D(f7),
        .FlushE(flush), .ZeroE(ze), .LtE(lte), .LtuE(ltue),
        .ImmSrcD(imm_d[0]), .ALUSrcAE(srca_e[0]), .ALUSrcBE(srcb_e[0]),
        .ALUControlE(alu0), .PCSrcE(pcsrc_e[0]), .JalrE(jalr_e[0]),
        .ResultSrcE(res_e[0]), .RegWriteM(rw_m[0]), .MemWriteM(mw_m[0]),
        .ResultSrcM(res_m[0]), .RegWriteW(rw_w[0]), .ResultSrcW(res_w[0]),
        .IllegalW(ill_w[0]), .IllegalSeen(seen[0])
    );

    pipe_controller #(
        .ALU_CTRL_W(3), .EN_JALR(1'b0), .EN_AUIPC(1'b0), .EN_FULL_BRANCH(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .OpD(op), .Funct3D(f3), .Funct7b5D(f7),
        .FlushE(flush), .ZeroE(ze), .LtE(lte), .LtuE(ltue),
        .ImmSrcD(imm_d[1]), .ALUSrcAE(srca_e[1]), .ALUSrcBE(srcb_e[1]),
        .ALUControlE(alu1), .PCSrcE(pcsrc_e[1]), .JalrE(jalr_e[1]),
        .ResultSrcE(res_e[1]), .RegWriteM(rw_m[1]), .MemWriteM(mw_m[1]),
        .ResultSrcM(res_m[1]), .RegWriteW(rw_w[1]), .ResultSrcW(res_w[1]),
        .IllegalW(ill_w[1]), .IllegalSeen(seen[1])
    );

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    // Reference decode, straight from the instruction table; k=1 is the reduced build.
    function automatic item_t ref_decode(input logic [6:0] o, input logic [2:0] fn3, input logic fb5, input int k);
        item_t r;
        logic bad, fbad;
        logic [3:0] fop;
        r = '0; bad = 1'b0; fbad = 1'b0; fop = 4'd0;
        case (fn3)
            3'd0: fop = (fb5 && o[5]) ? 4'd1 : 4'd0;
            3'd1: begin fop = 4'd6; fbad = (k == 1); end
            3'd2: fop = 4'd5;
            3'd4: fop = 4'd4;
            3'd5: begin fop = fb5 ? 4'd8 : 4'd7; fbad = (k == 1); end
            3'd6: fop = 4'd3;
            3'd7: fop = 4'd2;
            default: fbad = 1'b1;
        endcase
        case (o)
            7'b0000011: begin r.e.reg_write = 1; r.e.srcb = 1; r.e.res = 2'd1; end
            7'b0100011: begin r.e.mem_write = 1; r.imm = 3'd1; r.e.srcb = 1; end
            7'b0110011: begin r.e.reg_write = 1; r.e.alu = fop; bad = fbad; end
            7'b0010011: begin r.e.reg_write = 1; r.e.srcb = 1; r.e.alu = fop; bad = fbad; end
            7'b1100011: begin
                r.e.branch = 1; r.imm = 3'd2; r.e.alu = 4'd1; r.e.f3 = fn3;
                bad = (fn3 == 3'd2) || (fn3 == 3'd3) || (fn3[2] && k == 1);
            end
            7'b1101111: begin r.e.reg_write = 1; r.imm = 3'd3; r.e.res = 2'd2; r.e.jump = 1; end
            7'b1100111: begin
                if (k == 1) bad = 1'b1;
                else begin r.e.reg_write = 1; r.e.srcb = 1; r.e.res = 2'd2; r.e.jump = 1; r.e.jalr = 1; end
            end
            7'b0110111: begin r.e.reg_write = 1; r.imm = 3'd4; r.e.res = 2'd3; end
            7'b0010111: begin
                if (k == 1) bad = 1'b1;
                else begin r.e.reg_write = 1; r.imm = 3'd4; r.e.srca = 2'd2; r.e.srcb = 1; end
            end
            7'b0000000: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            r = '0;
            r.e.illegal = 1'b1;
        end
        return r;
    endfunction

    function automatic logic cond_taken(input logic [2:0] c, input logic z, input logic l, input logic lu);
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Driver: presents one Decode-cycle of inputs and queues what each DUT should show.
    task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] fn3, input logic fb5,
                         input logic fl, input logic z, input logic l, input logic lu);
        item_t it;
        rst = r; op = o; f3 = fn3; f7 = fb5; flush = fl; ze = z; lte = l; ltue = lu;
        for (int k = 0; k < 2; k++) begin
            it = ref_decode(o, fn3, fb5, k);
            it.rst = r;
            if (r || fl) it.e = '0;
            if (k == 0) exp_q0.push_back(it);
            else        exp_q1.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic bubble();
        drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: after each capture edge, advance the model pipeline and compare.
    always @(posedge clk) begin
        item_t it;
        logic exp_pc;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                if (exp_q0.size() == 0) continue;
                it = item_t'(exp_q0.pop_front());
            end else begin
                if (exp_q1.size() == 0) continue;
                it = item_t'(exp_q1.pop_front());
            end
            if (it.rst) begin
                mdl_e[k] = '0; mdl_m[k] = '0; mdl_w[k] = '0; mdl_seen[k] = 1'b0;
            end else begin
                mdl_w[k] = mdl_m[k];
                mdl_m[k] = mdl_e[k];
                mdl_e[k] = it.e;
                mdl_seen[k] = mdl_seen[k] | mdl_w[k].illegal;
            end
            exp_pc = mdl_e[k].jump | (mdl_e[k].branch & cond_taken(mdl_e[k].f3, ze, lte, ltue));
            check("imm_src_d", k, imm_d[k], it.imm);
            check("alu_src_a_e", k, srca_e[k], mdl_e[k].srca);
            check("alu_src_b_e", k, srcb_e[k], mdl_e[k].srcb);
            check("alu_ctrl_e", k, (k == 0) ? alu0 : {1'b0, alu1}, mdl_e[k].alu);
            check("pcsrc_e", k, pcsrc_e[k], exp_pc);
            check("jalr_e", k, jalr_e[k], mdl_e[k].jalr);
            check("result_src_e", k, res_e[k], mdl_e[k].res);
            check("reg_write_m", k, rw_m[k], mdl_m[k].reg_write);
            check("mem_write_m", k, mw_m[k], mdl_m[k].mem_write);
            check("result_src_m", k, res_m[k], mdl_m[k].res);
            check("reg_write_w", k, rw_w[k], mdl_w[k].reg_write);
            check("result_src_w", k, res_w[k], mdl_w[k].res);
            check("illegal_w", k, ill_w[k], mdl_w[k].illegal);
            check("illegal_seen", k, seen[k], mdl_seen[k]);
        end
    end

    logic [6:0] op_tab[10];

    initial begin
        op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};

        // Reset
        drive(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0110011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_rw_w", 0, rw_w[0], 1'b0);
        check("reset_pcsrc", 0, pcsrc_e[0], 1'b0);

        // R-type sub
        drive(1'b0, 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sub_alu_e", 0, alu0, 4'b0001);
        bubble(); bubble();
        check("sub_rw_w", 0, rw_w[0], 1'b1);
        check("sub_res_w", 0, res_w[0], 2'b00);

        // lw, then lw flushed in Execute
        drive(1'b0, 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw_res_e", 0, res_e[0], 2'b01);
        drive(1'b0, 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lw_rw_m", 0, rw_m[0], 1'b1);
        bubble();
        check("lw_flush_rw_m", 0, rw_m[0], 1'b0);

        // Branches
        drive(1'b0, 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bne_z1_pcsrc", 0, pcsrc_e[0], 1'b0);
        drive(1'b0, 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bne_z0_pcsrc", 0, pcsrc_e[0], 1'b1);
        drive(1'b0, 7'b1100011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bltu_pcsrc", 0, pcsrc_e[0], 1'b1);
        check("bltu_narrow_pcsrc", 1, pcsrc_e[1], 1'b0);
        bubble(); bubble();
        check("bltu_narrow_ill_w", 1, ill_w[1], 1'b1);

        // jalr
        drive(1'b0, 7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("jalr_e", 0, jalr_e[0], 1'b1);
        check("jalr_pcsrc", 0, pcsrc_e[0], 1'b1);
        check("jalr_off_jalr_e", 1, jalr_e[1], 1'b0);
        bubble(); bubble();
        check("jalr_res_w", 0, res_w[0], 2'b10);
        check("jalr_off_ill_w", 1, ill_w[1], 1'b1);
        check("jalr_off_rw_w", 1, rw_w[1], 1'b0);

        // Undefined opcode, then reset clears the sticky flag
        drive(1'b0, 7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bubble(); bubble();
        check("bad_op_ill_w", 0, ill_w[0], 1'b1);
        check("bad_op_seen", 0, seen[0], 1'b1);
        bubble();
        check("bad_op_ill_w_pulse", 0, ill_w[0], 1'b0);
        check("bad_op_seen_hold", 0, seen[0], 1'b1);
        drive(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_seen", 0, seen[0], 1'b0);

        // Shift on the 3-bit ALU build
        drive(1'b0, 7'b0110011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bubble(); bubble();
        check("narrow_sll_rw_w", 1, rw_w[1], 1'b0);
        check("narrow_sll_ill_w", 1, ill_w[1], 1'b1);
        check("wide_sll_rw_w", 0, rw_w[0], 1'b1);

        // Randomized stream
        for (int i = 0; i < 600; i++) begin
            int idx;
            logic [6:0] o;
            idx = $urandom_range(0, 10);
            o = (idx == 10) ? 7'($urandom_range(0, 127)) : op_tab[idx];
            drive(($urandom_range(0, 49) == 0), o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        check("queue_drained", 0, 8'(exp_q0.size() + exp_q1.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ALU_CTRL_W, 4, ALUControl width; legal values are 3 or 4.
- EN_JALR, 1, when 1 jalr decodes; when 0 it is illegal.
- EN_AUIPC, 1, when 1 auipc decodes; when 0 it is illegal.
- EN_FULL_BRANCH, 1, when 1 all six branch conditions decode; when 0 only beq and bne decode.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- OpD  in  7  opcode of the instruction in Decode.
- Funct3D  in  3  funct3 of the instruction in Decode.
- Funct7b5D  in  1  instr[30] of the instruction in Decode.
- FlushE  in  1  load a bubble into the Execute control register.
- ZeroE  in  1  ALU zero flag, Execute.
- LtE  in  1  signed less-than flag, Execute.
- LtuE  in  1  unsigned less-than flag, Execute.
- ImmSrcD  out  3  immediate select, combinational from Decode.
- ALUSrcAE  out  2  ALU A select: 00 rs1, 01 zero, 10 PC.
- ALUSrcBE  out  1  ALU B select: 0 rs2, 1 immediate.
- ALUControlE  out  ALU_CTRL_W  ALU operation.
- PCSrcE  out  1  redirect PC (taken branch or jump).
- JalrE  out  1  PC target comes from the ALU result.
- ResultSrcE  out  2  Execute copy, used by the hazard unit for load-use detection.
- RegWriteM, MemWriteM  out  1 each  Memory-stage controls.
- ResultSrcM  out  2  Memory-stage result select.
- RegWriteW  out  1  Writeback-stage register write.
- ResultSrcW  out  2  Writeback result select: 00 ALU, 01 memory, 10 PC+4, 11 ImmExt.
- IllegalW  out  1  one-cycle pulse when an illegal instruction reaches Writeback.
- IllegalSeen  out  1  sticky illegal-instruction flag.

Function
REQ-003 ImmSrc encoding SHALL be: 000 I, 001 S, 010 B, 011 J, 100 U.

REQ-004 Decode SHALL map each opcode to controls as follows:
- 0000011 load: RegWrite, I, B=imm, ResultSrc 01, add.
- 0100011 store: MemWrite, S, B=imm, add.
- 0110011 R-type: RegWrite, funct-decoded ALU op.
- 0010011 I-ALU: RegWrite, I, B=imm, funct-decoded ALU op.
- 1100011 branch: Branch, B, sub.
- 1101111 jal: RegWrite, J, ResultSrc 10, Jump.
- 1100111 jalr: RegWrite, I, B=imm, ResultSrc 10, Jump, Jalr, add.
- 0110111 lui: RegWrite, U, ResultSrc 11.
- 0010111 auipc: RegWrite, U, A=PC, B=imm, add.
- 0000000: bubble, all controls zero, not illegal.

REQ-005 ALUControl encoding SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000.

REQ-006 The funct-decoded ALU op SHALL follow funct3:
- 000: sub when Funct7b5D and OpD[5] are both 1, otherwise add.
- 001: sll.
- 010: slt.
- 100: xor.
- 101: sra when Funct7b5D is 1, otherwise srl.
- 110: or.
- 111: and.
- All other funct3 values are illegal.
- When ALU_CTRL_W=3, funct3 001 and 101 are illegal.

REQ-007 Branch funct3 SHALL select the taken condition:
- 000: ZeroE.
- 001: !ZeroE.
- 100: LtE.
- 101: !LtE.
- 110: LtuE.
- 111: !LtuE.
- 010 and 011 are illegal; 100 to 111 are also illegal when EN_FULL_BRANCH=0.

REQ-008 An undefined opcode, an illegal funct3, or an opcode disabled by parameter SHALL produce all-zero controls with IllegalD=1.

REQ-009 Branch condition and the Jalr flag SHALL be carried into Execute.

REQ-010 PCSrcE SHALL equal JumpE OR (BranchE AND the taken condition), computed combinationally.

REQ-011 Control for the instruction decoded at cycle n SHALL appear on the E outputs at n+1, the M outputs at n+2 and the W outputs at n+3.

REQ-012 FlushE=1 at edge n SHALL zero every Execute register, including the illegal bit; FlushE has priority over decoded values, so an illegal instruction flushed in Execute never raises IllegalW.

REQ-013 The M and W registers SHALL advance every cycle; the block has no stall path.

REQ-014 IllegalSeen SHALL set on the cycle IllegalW is 1 and hold until rst.

Reset
REQ-015 rst=1 at a rising edge SHALL zero the E, M and W registers and IllegalSeen, so every registered output is 0 and PCSrcE is 0.

REQ-016 rst SHALL override FlushE and any in-flight instruction.

REQ-017 rst mid-pipeline SHALL discard every in-flight control, with no residual RegWriteW or IllegalW afterwards.

Structure
REQ-018 Package ctrl_pkg SHALL hold:
- opcode constants;
- the ImmSrc, ResultSrc, ALUSrcA and ALUControl encodings;
- the branch funct3 constants.

REQ-019 ALU-op decoding SHALL live in sub-module alu_decoder, parametrised by ALU_CTRL_W, which outputs the ALU operation and a funct-illegal flag.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R-type sub: OpD=0110011, Funct3D=000, Funct7b5D=1 -> ALUControlE=0001 at n+1, RegWriteW=1 and ResultSrcW=00 at n+3.
- lw then FlushE: OpD=0000011 -> ResultSrcE=01 at n+1; a second lw with FlushE=1 on its capture edge -> RegWriteM=0 at n+2.
- Branches: bne (Funct3D=001) with ZeroE=1 -> PCSrcE=0; with ZeroE=0 -> PCSrcE=1. bltu (Funct3D=110) with LtuE=1 -> PCSrcE=1 when EN_FULL_BRANCH=1, and IllegalW=1 at n+3 when EN_FULL_BRANCH=0.
- jalr: OpD=1100111 with EN_JALR=1 -> JalrE=1, PCSrcE=1, ResultSrcW=10. The same opcode with EN_JALR=0 -> all controls 0 and IllegalW=1 at n+3.
- Illegal and reset: OpD=1111111 -> IllegalW high for exactly one cycle at n+3, IllegalSeen=1 afterwards; rst -> IllegalSeen=0.
- Narrow ALU: ALU_CTRL_W=3 with OpD=0110011, Funct3D=001 -> RegWriteW=0, IllegalW=1.
